// File: rtl/i2c_pkg.sv
// Shared constants for the I2C target: FSM encoding, ACK/NACK bus levels
// and the default 7-bit target address.
package i2c_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h55;

endpackage

// File: rtl/i2c_line_cond.sv
// Synchroniser plus edge detector for one asynchronous I2C line.
// Resets to the idle-high level so leaving reset never produces a false edge.
module i2c_line_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/i2c_target_regbuf.sv
// I2C target with a DEPTH x 8 register buffer, auto-incrementing pointer
// and a host port sharing the same buffer.
module i2c_target_regbuf
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
  parameter int         DEPTH       = 32,
  parameter int         PTR_W       = $clog2(DEPTH),
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             bus_wr_pulse,
  output logic [PTR_W-1:0] bus_wr_addr,
  output logic             addr_hit,
  output logic             busy
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [7:0] w_rx_byte;
  logic [7:0] w_mem_rd;

  logic [3:0]       r_state;
  logic [3:0]       r_bitcnt;
  logic [7:0]       r_shift;
  logic [PTR_W-1:0] r_ptr;
  logic             r_rw;
  logic             r_phase;
  logic             r_sda_oe;
  logic             r_busy;
  logic             r_addr_hit;
  logic             r_wr_pulse;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;
  logic [7:0]       r_host_rdata;
  logic [7:0]       r_mem [DEPTH];

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_scl_cond (
    .clk(clk), .rst(rst), .i_line(scl_i),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_sda_cond (
    .clk(clk), .rst(rst), .i_line(sda_i),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start   = w_sda_fall & w_scl;
  assign w_stop    = w_sda_rise & w_scl;
  assign w_rx_byte = {r_shift[6:0], w_sda};
  assign w_mem_rd  = r_mem[r_ptr];

  // r_phase marks the second half of an ACK slot: in the write-side ACK
  // states it means SDA is already pulled low, in RDATA_ACK that the master ACKed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_rw       <= 1'b0;
      r_phase    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_addr_hit <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_addr_hit <= 1'b0;
      r_wr_pulse <= 1'b0;
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state  <= ST_ADDR;
        r_bitcnt <= '0;
        r_sda_oe <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift  <= w_rx_byte;
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7) begin
                r_bitcnt <= '0;
                r_phase  <= 1'b0;
                r_rw     <= w_sda;
                // Address 0 is the general call and is never acknowledged
                if (w_rx_byte[7:1] == TARGET_ADDR && w_rx_byte[7:1] != 7'd0) begin
                  r_addr_hit <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ST_ADDR_ACK;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_phase  <= 1'b1;
                r_sda_oe <= ~I2C_ACK;
              end else begin
                r_phase  <= 1'b0;
                r_bitcnt <= '0;
                r_sda_oe <= 1'b0;
                if (r_state == ST_ADDR_ACK && r_rw) begin
                  r_state  <= ST_RDATA;
                  r_shift  <= w_mem_rd;
                  r_sda_oe <= ~w_mem_rd[7];
                end else if (r_state == ST_ADDR_ACK) begin
                  r_state <= ST_PTR;
                end else begin
                  r_state <= ST_WDATA;
                end
              end
            end
          end
          ST_PTR, ST_WDATA: begin
            if (w_scl_rise) begin
              r_shift  <= w_rx_byte;
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7) begin
                r_bitcnt <= '0;
                r_phase  <= 1'b0;
                if (r_state == ST_PTR) begin
                  r_ptr   <= w_rx_byte[PTR_W-1:0];
                  r_state <= ST_PTR_ACK;
                end else begin
                  r_wr_pulse <= 1'b1;
                  r_wr_addr  <= r_ptr;
                  r_wr_data  <= w_rx_byte;
                  r_ptr      <= r_ptr + PTR_W'(1);
                  r_state    <= ST_WDATA_ACK;
                end
              end
            end
          end
          ST_RDATA: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_ptr    <= r_ptr + PTR_W'(1);
                r_phase  <= 1'b0;
                r_state  <= ST_RDATA_ACK;
              end else begin
                r_shift  <= {r_shift[6:0], r_shift[7]};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          ST_RDATA_ACK: begin
            if (w_scl_rise) begin
              if (w_sda == I2C_NACK) begin
                r_state <= ST_IGNORE;
              end else begin
                r_phase <= 1'b1;
              end
            end else if (w_scl_fall && r_phase) begin
              r_phase  <= 1'b0;
              r_bitcnt <= '0;
              r_shift  <= w_mem_rd;
              r_sda_oe <= ~w_mem_rd[7];
              r_state  <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Bus commits land one cycle after the 8th bit, while bus_wr_pulse is high;
  // a host write to the same entry in that cycle is dropped.
  always_ff @(posedge clk) begin
    if (host_we && !(r_wr_pulse && host_addr == r_wr_addr)) begin
      r_mem[host_addr] <= host_wdata;
    end
    if (r_wr_pulse) begin
      r_mem[r_wr_addr] <= r_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_host_rdata <= '0;
    end else begin
      r_host_rdata <= r_mem[host_addr];
    end
  end

  assign sda_oe       = r_sda_oe;
  assign host_rdata   = r_host_rdata;
  assign bus_wr_pulse = r_wr_pulse;
  assign bus_wr_addr  = r_wr_addr;
  assign addr_hit     = r_addr_hit;
  assign busy         = r_busy;

endmodule

// File: doc/i2c_target_regbuf.md
Name: i2c_target_regbuf

Overview:
- Parametrised I2C target (slave) with a DEPTH x 8 register buffer and an auto-incrementing pointer.
- Filters and synchronises SCL/SDA, detects START, repeated START and STOP, and matches a 7-bit address.
- Serves master writes (first byte = pointer, rest = data) and master reads (data from the pointer onward).
- Local logic reads and writes the same buffer through a host port. Sits between the board I2C pins (open-drain pad outside) and the system logic.

Parameters:
- TARGET_ADDR, 7'h55, 7-bit address the block responds to.
- DEPTH, 32, buffer entries; power of two, 2..256.
- PTR_W, $clog2(DEPTH), pointer/host address width.
- SYNC_STAGES, 2, flip-flops in each SCL/SDA input synchroniser (>=2).

Ports:
- clk  in  1  system clock; must be >= 8x SCL rate.
- rst  in  1  reset, synchronous, active-high.
- scl_i  in  1  SCL pin input (asynchronous).
- sda_i  in  1  SDA pin input (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- host_we  in  1  host write strobe.
- host_addr  in  PTR_W  host buffer address.
- host_wdata  in  8  host write data.
- host_rdata  out  8  buffer[host_addr], registered, 1-cycle latency.
- bus_wr_pulse  out  1  1-cycle pulse when a bus byte is committed to the buffer.
- bus_wr_addr  out  PTR_W  address of the last bus write.
- addr_hit  out  1  1-cycle pulse on an address match (ACK phase entry).
- busy  out  1  high from a matched address until STOP or NACK-terminated transfer.

Behaviour:
- Reset values: all outputs 0, including sda_oe, host_rdata, bus_wr_addr and pointer. FSM = IDLE. Buffer contents are not reset.
- Input conditioning: SYNC_STAGES flops, then a previous-value register per line.
  - scl_rise/scl_fall = edge of synchronised SCL.
  - START = synchronised SDA falls while SCL high.
  - STOP = synchronised SDA rises while SCL high.
- Bus timing: SDA is sampled on scl_rise, MSB first. sda_oe is updated only on scl_fall; the one exception is STOP/START, which releases it immediately.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START from any state (repeated START included) -> ADDR. Bit counter is cleared; the pointer is kept.
- STOP from any state -> IDLE, sda_oe=0, busy=0.
- ADDR: shift 8 bits.
  - On the 8th scl_rise, if bits[7:1]==TARGET_ADDR: addr_hit pulses, busy=1, state -> ADDR_ACK. On the next scl_fall, sda_oe=1.
  - Mismatch -> IGNORE (no ACK, never drives).
- ADDR_ACK: on the scl_fall ending the ACK clock, sda_oe=0.
  - R/W=0 -> PTR.
  - R/W=1 -> RDATA. Load shift register = buffer[ptr]; drive MSB (sda_oe = ~bit).
- PTR: received byte sets ptr = byte mod DEPTH. ACK always, then -> WDATA.
- WDATA: on the 8th bit, write buffer[ptr]; bus_wr_pulse=1 and bus_wr_addr=ptr for one cycle; ptr = ptr+1 wrapping DEPTH-1 -> 0. ACK, return to WDATA.
- RDATA: shift the byte out, changing on scl_fall. After the 8th bit, release SDA and go to RDATA_ACK; ptr increments (wraps).
- RDATA_ACK: sample the master's ACK on scl_rise.
  - ACK (0) -> RDATA with the next byte loaded.
  - NACK (1) -> IGNORE; busy stays 1 until STOP.
- IGNORE: no drive; waits for START/STOP.
- Host port:
  - host_rdata <= buffer[host_addr] every cycle.
  - A host_we in the same cycle as a bus write to the same address: bus write wins, host write is dropped.
  - Host write to a different address in the same cycle: both complete (dual-write memory or 2-write register array).
- Reset mid-transfer: FSM -> IDLE and sda_oe released in the same cycle. The block does not respond until the next START.
- A general call (address 0) is not acknowledged.

Decomposition:
- Package i2c_pkg:
  - FSM state encoding localparams.
  - I2C_ACK=1'b0, I2C_NACK=1'b1.
  - Default TARGET_ADDR 7'h55.
- Sub-module i2c_line_cond (one per line, instantiated twice): synchroniser + edge detect, outputs level/rise/fall.
- START/STOP decode, FSM, shifter and buffer live in the top module.

Test Plan:
- Write: START, 0xAA (0x55,W), 0x03, 0x11, 0x22, STOP.
  - Expect ACK on all 4 bytes; host reads addr 3 = 0x11 and addr 4 = 0x22.
  - Two bus_wr_pulse, with bus_wr_addr 3 then 4; busy falls at STOP.
- Read with repeated START: host preloads buf[7]=0xC3, buf[8]=0x5A. Bus sends START, 0xAA, 0x07, Sr, 0xAB, reads 2 bytes (ACK then NACK), STOP.
  - Expect 0xC3 then 0x5A on SDA, and sda_oe=0 after the NACK.
- Address mismatch: START, 0x20 (0x10,W), 0x01, STOP.
  - sda_oe never asserts, no addr_hit, buffer unchanged.
- Wraparound (DEPTH=32): write pointer 0x1F, then data 0xEE, 0xDD.
  - Expect buf[31]=0xEE and buf[0]=0xDD.
- Collision: host_we to addr 5 (0x99) in the same cycle as bus commit of 0x44 to addr 5.
  - Expect buf[5]=0x44.
- Reset mid-transfer: assert rst during the 4th bit of the data byte.
  - sda_oe=0 next cycle, busy=0, a following STOP/START sequence is serviced normally.
